// File: rtl/hpc1_rnd_source_pkg.sv
// hpc1_rnd_source_pkg: shared HPC1 randomness counts, zero-seed substitute, FSM encoding and lane step
package hpc1_rnd_source_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEED,
        ST_WARMUP,
        ST_RUN
    } state_t;

    // The all-zero xorshift state is a fixed point, so a zero seed is replaced by this word
    localparam logic [31:0] ZERO_SEED_SUB = 32'h2545F491;

    function automatic int hpc1_refresh_bits(input int order);
        return (order + 1) * order / 2;
    endfunction

    function automatic int hpc1_mult_bits(input int order);
        return (order + 1) * order / 2;
    endfunction

    function automatic int hpc1_rnd_bits(input int order);
        return hpc1_refresh_bits(order) + hpc1_mult_bits(order);
    endfunction

    function automatic logic [31:0] xorshift32_step(input logic [31:0] x);
        logic [31:0] y;
        y = x ^ (x << 13);
        y = y ^ (y >> 17);
        return y ^ (y << 5);
    endfunction

endpackage

// File: rtl/hpc1_rnd_source_xorshift32_lane.sv
// xorshift32_lane: one seeded xorshift32 generator with load, step and truncated state output
module xorshift32_lane
    import hpc1_rnd_source_pkg::*;
#(
    parameter int OUT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [31:0]      i_seed,
    input  logic             i_step,
    output logic [OUT_W-1:0] o_state
);

    logic [31:0] r_state;

    // Loading a new seed wins over stepping; zero seeds are substituted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= '0;
        else if (i_load) r_state <= (i_seed == '0) ? ZERO_SEED_SUB : i_seed;
        else if (i_step) r_state <= xorshift32_step(r_state);
    end

    assign o_state = r_state[OUT_W-1:0];

endmodule

// File: rtl/hpc1_rnd_source.sv
// hpc1_rnd_source: fresh-randomness producer for HPC1 gadgets from a bank of seeded xorshift32 lanes
module hpc1_rnd_source
    import hpc1_rnd_source_pkg::*;
#(
    parameter int security_order = 2,
    parameter int NUM_GADGETS    = 1,
    parameter int RND_PER_GADGET = hpc1_rnd_bits(security_order),
    parameter int WARMUP_CYCLES  = 16
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic [31:0]                           seed_in,
    input  logic                                  seed_valid,
    output logic                                  seed_ready,
    output logic [NUM_GADGETS*RND_PER_GADGET-1:0] rnd_out,
    output logic                                  rnd_valid,
    input  logic                                  rnd_ready
);

    localparam int WIDTH   = NUM_GADGETS * RND_PER_GADGET;
    localparam int L       = (WIDTH + 31) / 32;
    localparam int CW      = (L > 1) ? $clog2(L) : 1;
    localparam int WW      = (WARMUP_CYCLES > 1) ? $clog2(WARMUP_CYCLES) : 1;
    localparam int WLAST   = (WARMUP_CYCLES > 0) ? WARMUP_CYCLES - 1 : 0;
    localparam bit MULTI   = L > 1;
    localparam bit NO_WARM = WARMUP_CYCLES == 0;

    state_t            r_state;
    state_t            w_next;
    logic [CW-1:0]     r_seed_cnt;
    logic [WW-1:0]     r_warm_cnt;
    logic              w_seed_acc;
    logic              w_last_seed;
    logic              w_warm_done;
    logic              w_step;
    logic [L-1:0]      w_load;
    logic [WIDTH-1:0]  w_lanes;

    assign seed_ready  = r_state != ST_WARMUP;
    assign rnd_valid   = r_state == ST_RUN;
    assign w_seed_acc  = seed_valid && seed_ready;
    assign w_last_seed = r_seed_cnt == CW'(L - 1);
    assign w_warm_done = r_warm_cnt == WW'(WLAST);
    assign w_step      = (r_state == ST_WARMUP) || (rnd_valid && rnd_ready && !w_seed_acc);
    assign rnd_out     = rnd_valid ? w_lanes : '0;

    genvar g;
    generate
        for (g = 0; g < L; g++) begin : g_lane
            localparam int OW = (g == L - 1) ? WIDTH - 32 * (L - 1) : 32;
            assign w_load[g] = w_seed_acc && ((r_state == ST_SEED) ? (r_seed_cnt == CW'(g)) : (g == 0));
            xorshift32_lane #(.OUT_W(OW)) u_lane (
                .clk     (clk),
                .rst_n   (rst_n),
                .i_load  (w_load[g]),
                .i_seed  (seed_in),
                .i_step  (w_step),
                .o_state (w_lanes[32*g +: OW])
            );
        end
    endgenerate

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else r_state <= w_next;
    end

    // Next state: a first seed word leaves IDLE/RUN, the last word or warm-up end moves on
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE, ST_RUN: if (w_seed_acc) w_next = MULTI ? ST_SEED : (NO_WARM ? ST_RUN : ST_WARMUP);
            ST_SEED:         if (w_seed_acc && w_last_seed) w_next = NO_WARM ? ST_RUN : ST_WARMUP;
            ST_WARMUP:       if (w_warm_done) w_next = ST_RUN;
        endcase
    end

    // Lane index of the next seed word; a word accepted outside SEED always lands in lane 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_seed_cnt <= '0;
        else if (w_seed_acc) r_seed_cnt <= (r_state == ST_SEED) ? r_seed_cnt + CW'(1) : CW'(1);
    end

    // Warm-up step counter, cleared outside WARMUP
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_warm_cnt <= '0;
        else r_warm_cnt <= (r_state == ST_WARMUP && !w_warm_done) ? r_warm_cnt + WW'(1) : '0;
    end

endmodule
